// File: rtl/mvm_sched_pkg.sv
// Shared types and sizing helpers for the MVM job scheduler.
// Optional build macro: MVM_TIMEOUT_EN (WAIT watchdog in mvm_job_scheduler).
package mvm_sched_pkg;

  // Job sequencing states, one per step of the engine load/run/drain protocol.
  typedef enum logic [3:0] {
    S_IDLE,
    S_GRANT,
    S_LDM_CMD,
    S_LDM_DATA,
    S_LDV_CMD,
    S_LDV_DATA,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_e;

  // Default geometry of the shared engine (mvm_8_8_8_1).
  localparam int unsigned K_DEF       = 8;
  localparam int unsigned N_DEF       = 2;
  localparam int unsigned MAT_WORDS   = K_DEF * K_DEF;
  localparam int unsigned VEC_WORDS   = K_DEF;

  // Counter/id width that never collapses to zero bits.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned WORD_CNT_W_DEF = width_of(MAT_WORDS);
  localparam int unsigned RSP_ID_W_DEF   = width_of(N_DEF);

endpackage

// File: rtl/mvm_job_scheduler_rr_arbiter.sv
// N-way round-robin arbiter: combinational winner search starting at a
// registered pointer; the pointer only moves when the owner reports a job end.
module rr_arbiter
  import mvm_sched_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = width_of(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          adv,
  input  logic [IW-1:0] adv_id,
  output logic          any,
  output logic [IW-1:0] winner
);

  logic [IW-1:0] ptr;

  // Pointer moves to one past the requester whose job just completed or aborted.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (int'(adv_id) == N - 1) ? '0 : adv_id + 1'b1;
    end
  end

  // Scan from the farthest slot back toward the pointer so the nearest active one wins.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    int idx;
    winner = '0;
    idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) winner = IW'(idx);
    end
  end

  assign any = |req;

endmodule

// File: rtl/mvm_job_scheduler.sv
// Shares one matrix-vector engine among N job sources. A job is K*K matrix
// words then K vector words; the scheduler loads the engine, starts it and
// forwards the K results tagged with the owning requester id.
// Optional build macro: MVM_TIMEOUT_EN adds a TIMEOUT-cycle watchdog on WAIT.
module mvm_job_scheduler
  import mvm_sched_pkg::*;
#(
  parameter  int N       = 2,
  parameter  int K       = 8,
  parameter  int B       = 8,
  parameter  int TIMEOUT = 64,
  localparam int IW      = width_of(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*B-1:0] req_data,
  output logic           core_reset,
  output logic           core_ldm,
  output logic           core_ldv,
  output logic           core_start,
  output logic [B-1:0]   core_din,
  input  logic           core_done,
  input  logic [2*B-1:0] core_dout,
  output logic           rsp_valid,
  output logic [IW-1:0]  rsp_id,
  output logic [2*B-1:0] rsp_data,
  output logic           rsp_last,
  output logic           err
);

  localparam int CW = width_of(K * K);

  state_e        state;
  logic [IW-1:0] grant;
  logic [CW-1:0] cnt;
  logic          done_q;
  logic          done_rise;
  logic          in_data;
  logic          gnt_valid;
  logic [B-1:0]  gnt_data;
  logic          gap_err;
  logic          timeout_hit;
  logic          abort;
  logic          job_end;
  logic          arb_any;
  logic [IW-1:0] arb_win;

  assign in_data   = (state == S_LDM_DATA) || (state == S_LDV_DATA);
  assign gnt_valid = req_valid[grant];
  assign gnt_data  = req_data[int'(grant)*B +: B];
  assign gap_err   = in_data && !gnt_valid;
  assign done_rise = core_done && !done_q;
  assign abort     = gap_err || timeout_hit;
  assign job_end   = abort || ((state == S_DRAIN) && (cnt == CW'(K - 1)));

  // Only the granted source sees ready, and only while its words are being streamed.
  always_comb begin
    req_ready = '0;
    if (in_data) req_ready[grant] = req_valid[grant];
  end

  rr_arbiter #(.N(N)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .adv    (job_end),
    .adv_id (grant),
    .any    (arb_any),
    .winner (arb_win)
  );

  // Previous done level, so a done that is already high is not taken as a new completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_q <= 1'b0;
    else        done_q <= core_done;
  end

`ifdef MVM_TIMEOUT_EN
  localparam int TW = width_of(TIMEOUT);
  logic [TW-1:0] tcnt;

  // Cycles spent in WAIT; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                tcnt <= '0;
    else if (state != S_WAIT)  tcnt <= '0;
    else                       tcnt <= tcnt + 1'b1;
  end

  assign timeout_hit = (state == S_WAIT) && !done_rise && (tcnt == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Job sequencer with registered engine controls, result stream and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      grant      <= '0;
      cnt        <= '0;
      core_reset <= 1'b0;
      core_ldm   <= 1'b0;
      core_ldv   <= 1'b0;
      core_start <= 1'b0;
      core_din   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_last   <= 1'b0;
      err        <= 1'b0;
    end else begin
      core_reset <= 1'b1;
      core_ldm   <= 1'b0;
      core_ldv   <= 1'b0;
      core_start <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_last   <= 1'b0;
      err        <= 1'b0;
      if (abort) begin
        // Abandon the job and clear the engine's partial state.
        err        <= 1'b1;
        core_reset <= 1'b0;
        cnt        <= '0;
        state      <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (arb_any) begin
              grant <= arb_win;
              state <= S_GRANT;
            end
          end
          S_GRANT: state <= S_LDM_CMD;
          S_LDM_CMD: begin
            // Pulse shows up while the first word is being accepted, so the
            // registered data words land on the engine back to back after it.
            core_ldm <= 1'b1;
            cnt      <= '0;
            state    <= S_LDM_DATA;
          end
          S_LDM_DATA: begin
            core_din <= gnt_data;
            if (cnt == CW'(K * K - 1)) begin
              cnt   <= '0;
              state <= S_LDV_CMD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_LDV_CMD: begin
            // First cycle carries the last matrix word, second is the idle gap.
            if (cnt == '0) begin
              cnt <= CW'(1);
            end else begin
              cnt      <= '0;
              core_ldv <= 1'b1;
              state    <= S_LDV_DATA;
            end
          end
          S_LDV_DATA: begin
            core_din <= gnt_data;
            if (cnt == CW'(K - 1)) begin
              cnt   <= '0;
              state <= S_START;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_START: begin
            // Same two-cycle spacing: last vector word, then idle, then start.
            if (cnt == '0) begin
              cnt <= CW'(1);
            end else begin
              cnt        <= '0;
              core_start <= 1'b1;
              state      <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (done_rise) begin
              cnt   <= '0;
              state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            rsp_valid <= 1'b1;
            rsp_id    <= grant;
            rsp_data  <= core_dout;
            rsp_last  <= (cnt == CW'(K - 1));
            if (cnt == CW'(K - 1)) begin
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
